// File: rtl/power_mode_sequencer.sv
// power_mode_sequencer: accepts a one-hot power mode and ramps the power level toward its target
module power_mode_sequencer #(
    parameter int STEP_CYCLES  = 4,
    parameter int TRAINING_LVL = 2,
    parameter int DUELING_LVL  = 5,
    parameter int BULKHEAD_LVL = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] mode_in,
    input  logic       mode_valid,
    output logic       mode_ready,
    output logic [2:0] level,
    output logic [2:0] mode_active,
    output logic       ramping,
    output logic       err
);
    typedef enum logic {IDLE, RAMP} state_t;
    state_t     state;
    logic [2:0] target;
    logic [2:0] pending_mode;
    logic [7:0] cnt;
    logic [2:0] tgt;
    logic       onehot;
    logic [2:0] nxt;
    assign mode_ready = (state == IDLE);
    assign ramping    = (state == RAMP);
    // Decode the requested target level and the next one-step level move
    always_comb begin
        onehot = (mode_in == 3'b001) || (mode_in == 3'b010) || (mode_in == 3'b100);
        tgt    = (mode_in == 3'b001) ? 3'(TRAINING_LVL) :
                 (mode_in == 3'b010) ? 3'(DUELING_LVL) : 3'(BULKHEAD_LVL);
        nxt    = (level < target) ? level + 3'd1 : level - 3'd1;
    end
    // Handshake, validation and stepped ramp; level never equals target while in RAMP
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            level        <= 3'd0;
            mode_active  <= 3'b000;
            err          <= 1'b0;
            cnt          <= 8'd0;
            target       <= 3'd0;
            pending_mode <= 3'b000;
        end else begin
            err <= 1'b0;
            if (state == IDLE) begin
                if (mode_valid) begin
                    if (!onehot) begin
                        err <= 1'b1;
                    end else if (tgt == level) begin
                        mode_active <= mode_in;
                    end else begin
                        mode_active  <= 3'b000;
                        pending_mode <= mode_in;
                        target       <= tgt;
                        cnt          <= 8'd0;
                        state        <= RAMP;
                    end
                end
            end else if (cnt == 8'(STEP_CYCLES - 1)) begin
                cnt   <= 8'd0;
                level <= nxt;
                if (nxt == target) begin
                    mode_active <= pending_mode;
                    state       <= IDLE;
                end
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_power_mode_sequencer.sv
// tb_power_mode_sequencer: table-driven directed checks of the power mode sequencer
module tb_power_mode_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] mode_in = 3'b000;
    logic       mode_valid = 1'b0;
    logic       mode_ready;
    logic [2:0] level;
    logic [2:0] mode_active;
    logic       ramping;
    logic       err;
    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] mode;
        logic [2:0] lvl0;
        logic [2:0] lvl1;
        logic [2:0] act;
        logic       bad;
    } vec_t;
    vec_t vecs[11];

    power_mode_sequencer dut (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_valid(mode_valid),
        .mode_ready(mode_ready), .level(level), .mode_active(mode_active),
        .ramping(ramping), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string nm, input logic [2:0] lvl, input logic [2:0] act);
        chk({nm, " level"}, 8'(level), 8'(lvl));
        chk({nm, " active"}, 8'(mode_active), 8'(act));
        chk({nm, " ready"}, 8'(mode_ready), 8'd1);
        chk({nm, " ramping"}, 8'(ramping), 8'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int d;
        int steps;
        int e;
        string nm;
        nm = $sformatf("vec%0d", idx);
        mode_in = v.mode;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        if (v.bad) begin
            chk({nm, " err"}, 8'(err), 8'd1);
            chk_idle(nm, v.lvl0, v.act);
            tick();
            chk({nm, " err clear"}, 8'(err), 8'd0);
            chk_idle({nm, " after"}, v.lvl0, v.act);
        end else if (v.lvl0 == v.lvl1) begin
            chk({nm, " err"}, 8'(err), 8'd0);
            chk_idle({nm, " same"}, v.lvl1, v.act);
        end else begin
            d = (v.lvl1 > v.lvl0) ? int'(v.lvl1) - int'(v.lvl0) : int'(v.lvl0) - int'(v.lvl1);
            chk({nm, " ramp start"}, 8'(ramping), 8'd1);
            chk({nm, " ready low"}, 8'(mode_ready), 8'd0);
            chk({nm, " active cleared"}, 8'(mode_active), 8'd0);
            for (int c = 1; c <= d * 4; c++) begin
                tick();
                steps = c / 4;
                e = (v.lvl1 > v.lvl0) ? int'(v.lvl0) + steps : int'(v.lvl0) - steps;
                chk($sformatf("%s level c%0d", nm, c), 8'(level), 8'(e));
                if (c < d * 4) begin
                    chk($sformatf("%s ramping c%0d", nm, c), 8'(ramping), 8'd1);
                    chk($sformatf("%s active c%0d", nm, c), 8'(mode_active), 8'd0);
                end
            end
            chk_idle({nm, " done"}, v.lvl1, v.act);
        end
    endtask

    initial begin
        vecs[0]  = '{3'b001, 3'd7, 3'd2, 3'b001, 1'b0};
        vecs[1]  = '{3'b011, 3'd2, 3'd2, 3'b001, 1'b1};
        vecs[2]  = '{3'b000, 3'd2, 3'd2, 3'b001, 1'b1};
        vecs[3]  = '{3'b001, 3'd2, 3'd2, 3'b001, 1'b0};
        vecs[4]  = '{3'b010, 3'd2, 3'd5, 3'b010, 1'b0};
        vecs[5]  = '{3'b111, 3'd5, 3'd5, 3'b010, 1'b1};
        vecs[6]  = '{3'b110, 3'd5, 3'd5, 3'b010, 1'b1};
        vecs[7]  = '{3'b101, 3'd5, 3'd5, 3'b010, 1'b1};
        vecs[8]  = '{3'b100, 3'd5, 3'd7, 3'b100, 1'b0};
        vecs[9]  = '{3'b100, 3'd7, 3'd7, 3'b100, 1'b0};
        vecs[10] = '{3'b001, 3'd7, 3'd2, 3'b001, 1'b0};

        tick();
        tick();
        chk("reset err", 8'(err), 8'd0);
        chk_idle("reset", 3'd0, 3'b000);

        mode_in = 3'b100;
        mode_valid = 1'b1;
        tick();
        chk_idle("rst priority", 3'd0, 3'b000);
        rst = 1'b0;

        tick();
        chk("hold accept ramping", 8'(ramping), 8'd1);
        mode_in = 3'b010;
        for (int c = 1; c <= 28; c++) begin
            tick();
            if (c % 4 == 0) chk($sformatf("hold level c%0d", c), 8'(level), 8'(c / 4));
            if (c == 14) chk("hold mid ramping", 8'(ramping), 8'd1);
            if (c == 14) chk("hold mid active", 8'(mode_active), 8'd0);
        end
        mode_valid = 1'b0;
        chk_idle("hold done", 3'd7, 3'b100);
        tick();
        chk_idle("hold settled", 3'd7, 3'b100);

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        mode_in = 3'b100;
        mode_valid = 1'b1;
        tick();
        mode_valid = 1'b0;
        for (int c = 1; c <= 10; c++) tick();
        chk("mid ramp level", 8'(level), 8'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset err", 8'(err), 8'd0);
        chk_idle("midreset", 3'd0, 3'b000);
        run_vec(11, '{3'b010, 3'd0, 3'd5, 3'b010, 1'b0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/power_mode_sequencer.md
# power_mode_sequencer

Consumer side of the registered one-hot power-setting bus (training 001, dueling 010, bulkheads 100). Accepts a requested mode through a valid/ready handshake and validates the code. Ramps a 3-bit power level one step at a time toward the level assigned to that mode, then reports the mode as active. Sits directly downstream of the power-setting register and drives the power-level consumers.

## Interface
- STEP_CYCLES, 4, clock cycles per one-level step; legal range 1..255
- TRAINING_LVL, 2, target level for mode 001; legal range 0..7
- DUELING_LVL, 5, target level for mode 010; legal range 0..7
- BULKHEAD_LVL, 7, target level for mode 100; legal range 0..7

- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- mode_in  in  3  requested mode code; must be one-hot
- mode_valid  in  1  request present
- mode_ready  out  1  high only in IDLE
- level  out  3  current power level, registered
- mode_active  out  3  engaged mode; 000 when none is engaged or a ramp is in progress
- ramping  out  1  high in RAMP
- err  out  1  one-cycle pulse on rejected code

## Operation
- States: IDLE, RAMP. mode_ready = (state==IDLE); ramping = (state==RAMP).
- Registers: level, target, pending_mode, mode_active, step counter (8 bit), err.
- Handshake: request accepted on a posedge with mode_valid & mode_ready. No queueing; valid while RAMP is ignored.
- Accepted with non-one-hot mode_in (000, 011, 101, 110, 111):
  - err=1 for exactly the next cycle.
  - level, mode_active and state unchanged.
- Accepted with one-hot code, target T looked up from the parameters:
  - T == level: mode_active <= mode_in at that edge; stay IDLE.
  - T != level: mode_active <= 000, pending_mode <= mode_in, target <= T, counter <= 0, go to RAMP.
- RAMP:
  - Counter increments each cycle.
  - When counter == STEP_CYCLES-1: counter <= 0 and level steps ±1 toward target.
  - On the edge where level becomes target: mode_active <= pending_mode and state goes to IDLE.
- Level arithmetic: unsigned 3-bit, moving by exactly 1 per step. It never wraps (0↔7) and never overshoots target.
- Reset at any time, including mid-ramp, at the next posedge:
  - state=IDLE, level=0, mode_active=000, err=0, counter=0, target=0, pending_mode=000.
  - Resulting outputs: mode_ready=1, ramping=0.
- rst has priority over a simultaneous handshake.

## Timing
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs.
- Acceptance at edge k with a level distance D = |T − level| > 0:
  - level changes at edges k + n·STEP_CYCLES, for n = 1..D.
  - mode_active and mode_ready rise at edge k + D·STEP_CYCLES.
  - ramping is high from edge k until that edge.
- Same-level request: mode_active updates at edge k; mode_ready never drops.
- err: high from rejection edge k to edge k+1.
- Back-to-back: a new request may be accepted on the edge right after mode_ready returns high.
- STEP_CYCLES=1: one level step per cycle.

## Test plan
- After reset, with STEP_CYCLES=4, request 100:
  - ready drops; level reaches 1,2,…,7 at edges +4,+8,…,+28.
  - mode_active=000 throughout the ramp, then 100 with ready=1 at edge +28.
- From bulkhead (level 7), request 001: level steps 6,5,4,3,2 at +4…+20; mode_active=001 at +20.
- In IDLE at training, request 011, then 000: err is high for one cycle each; level stays 2, mode_active stays 001, ready stays 1.
- During a ramp toward 7, hold mode_valid=1 with 010: the request is ignored, the ramp completes at 7 and mode_active=100.
- At training level 2, request 001 again: mode_active=001 at the next edge, no ramp, ready never low.
- Assert rst at the 3rd step of a ramp: the next edge gives level=0, mode_active=000, ready=1, ramping=0, err=0; a following request 010 ramps from 0 to 5 in 20 cycles.
